reg_pipe_chain: RTL and testbench
=================================

// Module: reg_pipe_chain
// PURPOSE
//   Parametrised chain of DEPTH data registers, each WIDTH bits, with valid/ready flow control.
//   Each stage has its own valid flag, and backpressure propagates stage by stage.
//   Empty stages (bubbles) are collapsed: data advances into any empty stage ahead of it.
//   Supports a synchronous flush and a programmable reset value.
//   Used as the general retiming/delay element between datapath blocks.
// PARAMETERS
//   WIDTH    8  data width in bits (>=1)
//   DEPTH    4  number of register stages (>=1)
//   RST_VAL  0  WIDTH-bit value loaded into every data register on reset or flush
// PORTS
//   clk        in   1                   rising-edge clock
//   reset      in   1                   synchronous, active-high reset
//   flush      in   1                   synchronous clear of all stages
//   in_valid   in   1                   upstream data valid
//   in_ready   out  1                   chain can accept in_data this cycle
//   in_data    in   WIDTH               upstream data
//   out_valid  out  1                   valid flag of stage DEPTH-1
//   out_ready  in   1                   downstream accepts out_data
//   out_data   out  WIDTH               data of stage DEPTH-1
//   occupancy  out  $clog2(DEPTH+1)     number of valid stages
// BEHAVIOUR
//   - Stage state: v[i] and d[i] for i = 0..DEPTH-1.
//     - Stage 0 is the input stage; stage DEPTH-1 drives out_*.
//   - Ready chain (combinational):
//     - rdy[DEPTH] = out_ready
//     - rdy[i] = !v[i] | rdy[i+1]
//     - in_ready = rdy[0] & !flush
//   - Stage update on posedge clk, when rdy[i] is 1:
//     - v[i] <= v[i-1], d[i] <= d[i-1]
//     - For stage 0, the source is in_valid / in_data, gated by !flush.
//   - Stage hold: when rdy[i] is 0, stage i holds v[i] and d[i].
//   - Data gating: d[i] is written only when the incoming valid is 1; otherwise d[i] holds.
//   - Handshakes:
//     - Input transfer = in_valid & in_ready.
//     - Output transfer = out_valid & out_ready.
//     - out_data stays stable while out_valid=1 and out_ready=0.
//   - Latency and throughput:
//     - DEPTH cycles from input transfer to out_valid when the chain is free-flowing.
//     - Sustained throughput is 1 word per cycle.
//     - A lone word in a stalled chain still advances to stage DEPTH-1 (bubble collapse).
//   - Ordering: words leave strictly in acceptance order. No duplication and no loss, except by flush or reset.
//   - Full condition: all v=1 and out_ready=0 -> in_ready=0.
//   - Simultaneous pop and push when full: in_ready=1 while out_ready=1, so the chain stays full.
//   - occupancy:
//     - Registered counter.
//     - Increments on an input transfer only and decrements on an output transfer only; both or neither -> unchanged.
//     - Must equal popcount(v) every cycle.
//   - flush (sampled on posedge clk):
//     - All v <= 0, all d <= RST_VAL, occupancy <= 0.
//     - in_data offered in the flush cycle is dropped, since in_ready=0.
//     - out_valid and out_data remain visible in the flush cycle. A downstream pop in that cycle counts as a transfer.
//   - reset:
//     - Highest priority over flush and data movement, and may be asserted mid-stream.
//     - On reset: all v=0, all d=RST_VAL, occupancy=0, out_valid=0, out_data=RST_VAL.
//     - in_ready is combinational from state, so it reads 1 after reset.
//   - DEPTH=1: the chain degenerates to a single registered stage with the same rules.
// TESTING
//   1. Reset: assert reset for 2 cycles with in_valid=1 -> out_valid=0, out_data=RST_VAL, occupancy=0 on release.
//   2. Stream: DEPTH=4, out_ready=1, push 0x11,0x22,0x33,0x44 back to back -> 0x11 is on out_data 4 cycles after its accept, followed by one word per cycle.
//   3. Backpressure: out_ready=0, in_valid=1 continuously -> exactly 4 accepts, then in_ready=0, occupancy=4.
//      Then set out_ready=1 -> 4 words drain in order.
//   4. Bubble collapse: out_ready=0, push a single 0xA5 -> out_valid=1 with 0xA5 after 4 cycles, occupancy=1, in_ready=1.
//   5. Full push and pop: full chain, out_ready=1, in_valid=1 -> pop and push in the same cycle, occupancy stays 4, order is preserved.
//   6. Flush and reset mid-stream:
//      - flush with 3 words held -> next cycle occupancy=0 and out_valid=0; the word offered during flush is never output.
//      - Repeat with reset instead of flush -> same result.

Source files
------------

// File: rtl/reg_pipe_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipe_chain_if
// Description : Upstream/downstream valid-ready bundle for reg_pipe_chain.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_pipe_chain_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // master: the environment around the chain (producer and consumer)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // slave: the chain itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/reg_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipe_chain
// Description : DEPTH-stage valid/ready register chain with bubble collapse,
//               synchronous flush and programmable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pipe_chain #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              OCC_W   = $clog2(DEPTH + 1)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              flush,
  reg_pipe_chain_if.slave        bus,
  output logic [OCC_W-1:0]       occupancy
);

  localparam logic [OCC_W-1:0] C_OCC_ONE = OCC_W'(1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_src_v;
  logic [WIDTH-1:0] w_src_d [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Closed form of rdy[i] = !v[i] | rdy[i+1]: a stage is blocked only when it
  // and every stage downstream of it is full and the consumer is stalled.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign w_rdy[i] = bus.out_ready | ~(&r_v[DEPTH-1:i]);
    if (i == 0) begin : g_head
      assign w_src_v[i] = bus.in_valid & ~flush;
      assign w_src_d[i] = bus.in_data;
    end else begin : g_body
      assign w_src_v[i] = r_v[i-1];
      assign w_src_d[i] = r_d[i-1];
    end
  end

  assign bus.in_ready  = w_rdy[0] & ~flush;
  assign bus.out_valid = r_v[DEPTH-1];
  assign bus.out_data  = r_d[DEPTH-1];
  assign occupancy     = r_occ;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = r_v[DEPTH-1] & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_src_v[i];
          if (w_src_v[i]) begin
            r_d[i] <= w_src_d[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occ <= '0;
    end else if (w_push && !w_pop) begin
      r_occ <= r_occ + C_OCC_ONE;
    end else if (w_pop && !w_push) begin
      r_occ <= r_occ - C_OCC_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_pipe_chain
// Description : Directed, table-driven self-checking bench for reg_pipe_chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_pipe_chain;

  localparam int               WIDTH   = 8;
  localparam int               DEPTH   = 4;
  localparam logic [WIDTH-1:0] RST_VAL = 8'h5A;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] occupancy;
  int         n_checks = 0;
  int         n_fail   = 0;
  vec_t       vq[$];

  reg_pipe_chain_if #(.WIDTH(WIDTH)) bus ();

  reg_pipe_chain #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RST_VAL(RST_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [7:0] id,
                     input logic ordy, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_od, input int e_occ);
    vq.push_back('{r, f, iv, id, ordy, e_ir, e_ov, e_od, 3'(e_occ)});
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] id,
                       input logic ordy);
    @(negedge clk);
    reset         = r;
    flush         = f;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // r  f  iv  data   or  ir ov  out    occ
    // stream, free flowing
    add(0, 0, 1, 8'h11, 1,  1, 0, 8'h5A, 1);
    add(0, 0, 1, 8'h22, 1,  1, 0, 8'h5A, 2);
    add(0, 0, 1, 8'h33, 1,  1, 0, 8'h5A, 3);
    add(0, 0, 1, 8'h44, 1,  1, 1, 8'h11, 4);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'h22, 3);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'h33, 2);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'h44, 1);
    add(0, 0, 0, 8'h00, 1,  1, 0, 8'h44, 0);
    // backpressure: four accepts, then blocked, then drain
    add(0, 0, 1, 8'h55, 0,  1, 0, 8'h44, 1);
    add(0, 0, 1, 8'h66, 0,  1, 0, 8'h44, 2);
    add(0, 0, 1, 8'h77, 0,  1, 0, 8'h44, 3);
    add(0, 0, 1, 8'h88, 0,  1, 1, 8'h55, 4);
    add(0, 0, 1, 8'h99, 0,  0, 1, 8'h55, 4);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'h66, 3);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'h77, 2);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'h88, 1);
    add(0, 0, 0, 8'h00, 1,  1, 0, 8'h88, 0);
    // lone word collapses to the last stage under stall
    add(0, 0, 1, 8'hA5, 0,  1, 0, 8'h88, 1);
    add(0, 0, 0, 8'h00, 0,  1, 0, 8'h88, 1);
    add(0, 0, 0, 8'h00, 0,  1, 0, 8'h88, 1);
    add(0, 0, 0, 8'h00, 0,  1, 1, 8'hA5, 1);
    add(0, 0, 0, 8'h00, 0,  1, 1, 8'hA5, 1);
    // fill behind it, then push and pop together while full
    add(0, 0, 1, 8'hB1, 0,  1, 1, 8'hA5, 2);
    add(0, 0, 1, 8'hB2, 0,  1, 1, 8'hA5, 3);
    add(0, 0, 1, 8'hB3, 0,  1, 1, 8'hA5, 4);
    add(0, 0, 1, 8'hC1, 1,  1, 1, 8'hB1, 4);
    add(0, 0, 1, 8'hC2, 1,  1, 1, 8'hB2, 4);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'hB3, 3);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'hC1, 2);
    add(0, 0, 0, 8'h00, 1,  1, 1, 8'hC2, 1);
    add(0, 0, 0, 8'h00, 1,  1, 0, 8'hC2, 0);
    // flush with three words held; offered word is dropped
    add(0, 0, 1, 8'hD1, 0,  1, 0, 8'hC2, 1);
    add(0, 0, 1, 8'hD2, 0,  1, 0, 8'hC2, 2);
    add(0, 0, 1, 8'hD3, 0,  1, 0, 8'hC2, 3);
    add(0, 1, 1, 8'hEE, 0,  0, 0, 8'h5A, 0);
    add(0, 0, 0, 8'h00, 1,  1, 0, 8'h5A, 0);
    add(0, 0, 0, 8'h00, 1,  1, 0, 8'h5A, 0);
    // same with reset
    add(0, 0, 1, 8'hF1, 0,  1, 0, 8'h5A, 1);
    add(0, 0, 1, 8'hF2, 0,  1, 0, 8'h5A, 2);
    add(0, 0, 1, 8'hF3, 0,  1, 0, 8'h5A, 3);
    add(1, 0, 1, 8'hEE, 0,  1, 0, 8'h5A, 0);
    add(0, 0, 0, 8'h00, 1,  1, 0, 8'h5A, 0);
    add(0, 0, 0, 8'h00, 1,  1, 0, 8'h5A, 0);

    // reset held two cycles with a word offered
    drive(1, 0, 1, 8'h77, 1);
    drive(1, 0, 1, 8'h77, 1);
    drive(0, 0, 0, 8'h00, 1);
    #4;
    chk("reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset out_data",  32'(bus.out_data),  32'(RST_VAL));
    chk("reset occupancy", 32'(occupancy),     32'h0);
    chk("reset in_ready",  32'(bus.in_ready),  32'h1);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].fl, vq[k].iv, vq[k].id, vq[k].ordy);
      #4;
      chk($sformatf("v%0d in_ready", k), 32'(bus.in_ready), 32'(vq[k].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", k), 32'(bus.out_valid), 32'(vq[k].e_ov));
      chk($sformatf("v%0d out_data", k),  32'(bus.out_data),  32'(vq[k].e_od));
      chk($sformatf("v%0d occupancy", k), 32'(occupancy),     32'(vq[k].e_occ));
    end

    // flush while the head word is visible and being popped
    drive(0, 0, 1, 8'hA1, 0);
    drive(0, 0, 1, 8'hA2, 0);
    drive(0, 0, 1, 8'hA3, 0);
    drive(0, 0, 0, 8'h00, 0);
    drive(0, 1, 1, 8'hEE, 1);
    #4;
    chk("flush-cycle out_valid", 32'(bus.out_valid), 32'h1);
    chk("flush-cycle out_data",  32'(bus.out_data),  32'hA1);
    chk("flush-cycle in_ready",  32'(bus.in_ready),  32'h0);
    chk("flush-cycle occupancy", 32'(occupancy),     32'h4 - 32'h1);
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 8'h00, 1);
      #4;
      chk($sformatf("post-flush c%0d out_valid", c), 32'(bus.out_valid), 32'h0);
      chk($sformatf("post-flush c%0d occupancy", c), 32'(occupancy),     32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
